// File: rtl/puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : puf_challenge_ctrl
//  Purpose  : Sequencer for an arbiter-PUF swap-stage chain. Drives a
//             challenge onto the stage selects, fires N_EVAL launch pulses,
//             samples the arbiter after each race and majority-votes the
//             response.
//  Revision : 1.0  initial release
// ============================================================================
module puf_challenge_ctrl #(
    parameter  int N_STAGES   = 64,
    parameter  int SETTLE_CYC = 4,
    parameter  int RACE_CYC   = 8,
    parameter  int N_EVAL     = 5,
    localparam int c_ones_w   = $clog2(N_EVAL + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_STAGES-1:0] challenge,
    output logic [N_STAGES-1:0] chal_out,
    output logic                launch,
    input  logic                arb_in,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp,
    output logic [c_ones_w-1:0] ones_cnt,
    output logic                busy
);

    // State encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_settle = 3'd1;
    localparam logic [2:0] c_st_fire   = 3'd2;
    localparam logic [2:0] c_st_sample = 3'd3;
    localparam logic [2:0] c_st_relax  = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    // Phase timer sized for the longer of the two timed phases
    localparam int c_tmr_max = (SETTLE_CYC > RACE_CYC) ? SETTLE_CYC : RACE_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0]  c_settle_last = c_tmr_w'(SETTLE_CYC - 1);
    localparam logic [c_tmr_w-1:0]  c_race_last   = c_tmr_w'(RACE_CYC - 1);
    localparam logic [c_ones_w-1:0] c_eval_last   = c_ones_w'(N_EVAL - 1);
    localparam logic [c_ones_w-1:0] c_half        = c_ones_w'(N_EVAL / 2);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_tmr_w-1:0]  r_tmr;
    logic [c_ones_w-1:0] r_evals;
    logic [c_ones_w-1:0] r_ones;
    logic [N_STAGES-1:0] r_chal;
    logic                r_launch;
    logic                w_timed;

    // A tie in the vote is impossible only for odd evaluation counts
    a_neval_odd: assert property (@(posedge clk) (N_EVAL % 2) == 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (req_valid)               w_state_nxt = c_st_settle;
            c_st_settle: if (r_tmr == c_settle_last)  w_state_nxt = c_st_fire;
            c_st_fire:   if (r_tmr == c_race_last)    w_state_nxt = c_st_sample;
            c_st_sample: w_state_nxt = (r_evals == c_eval_last) ? c_st_done : c_st_relax;
            c_st_relax:  if (r_tmr == c_settle_last)  w_state_nxt = c_st_fire;
            c_st_done:   if (resp_ready)              w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    assign w_timed = (r_state == c_st_settle) || (r_state == c_st_fire) ||
                     (r_state == c_st_relax);

    // Datapath: phase timer, challenge latch, launch flop, vote counters.
    // launch is a delayed copy of FIRE: it rises one cycle into FIRE and
    // covers the SAMPLE cycle, so the chain races for exactly RACE_CYC
    // cycles before the arbiter is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr    <= '0;
            r_evals  <= '0;
            r_ones   <= '0;
            r_chal   <= '0;
            r_launch <= 1'b0;
        end else begin
            r_launch <= (r_state == c_st_fire);
            if (w_timed && (w_state_nxt == r_state)) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end
            if ((r_state == c_st_idle) && req_valid) begin
                r_chal  <= challenge;
                r_evals <= '0;
                r_ones  <= '0;
            end
            if (r_state == c_st_sample) begin
                r_evals <= r_evals + 1'b1;
                r_ones  <= r_ones + c_ones_w'(arb_in);
            end
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        req_ready  = (r_state == c_st_idle);
        busy       = (r_state != c_st_idle);
        resp_valid = (r_state == c_st_done);
        resp       = (r_ones > c_half);
    end

    assign chal_out = r_chal;
    assign launch   = r_launch;
    assign ones_cnt = r_ones;

endmodule
`default_nettype wire
